// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-zero index, memory-control bundle and access sizes.
package cpu_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic unsigned_ext;
        logic byte_en;
        logic half_en;
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Byte wins when both size bits are set.
    function automatic acc_size_t acc_size(input logic byte_en, input logic half_en);
        acc_size_t sz;
        if (byte_en) begin
            sz = SZ_BYTE;
        end else if (half_en) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational alignment check for a memory access; reusable for fetch addresses.
module mem_align_chk
    import cpu_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic       byte_en,
    input  logic       half_en,
    input  logic       access,
    output logic       misaligned
);

    acc_size_t size_s;

    // Decode access size and flag addresses that break its natural alignment.
    always_comb begin
        size_s     = acc_size(byte_en, half_en);
        misaligned = 1'b0;
        if (access) begin
            case (size_s)
                SZ_BYTE: misaligned = 1'b0;
                SZ_HALF: misaligned = addr_lo[0];
                SZ_WORD: misaligned = (addr_lo != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end else begin
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, WB store-data forwarding and snooping,
// and misaligned-access squashing with a sticky fault address.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rt_data_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  dst_in,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemtoReg_in,
    input  logic              UnsignedExt_in,
    input  logic              Byte_in,
    input  logic              Half_in,
    input  logic              wb_RegWrite,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              err_ack,
    output logic [DATA_W-1:0] R1_in,
    output logic [DATA_W-1:0] data_in,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              UnsignedExt_Mem,
    output logic              Byte,
    output logic              Half,
    output logic              RegWrite,
    output logic [REG_W-1:0]  dst,
    output logic              valid,
    output logic              addr_err,
    output logic [DATA_W-1:0] bad_addr,
    output logic              fault
);

    mem_ctrl_t         ctrl_r;
    mem_ctrl_t         cap_ctrl_s;
    logic              valid_r;
    logic              addr_err_r;
    logic              fault_r;
    logic [DATA_W-1:0] r1_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] bad_addr_r;
    logic [DATA_W-1:0] cap_data_s;
    logic [REG_W-1:0]  dst_r;
    logic [REG_W-1:0]  rt_r;
    logic              misaligned_s;
    logic              access_s;
    logic              capture_s;
    logic              fwd_s;
    logic              snoop_s;

    assign access_s  = valid_in & (MemWrite_in | MemtoReg_in);
    assign capture_s = ~flush & ~stall;
    assign fwd_s     = wb_RegWrite & (wb_dst == rt_in) & (rt_in != REG_W'(REG_ZERO));
    // Held rt lets a stalled store pick up a register written back while it waits.
    assign snoop_s   = wb_RegWrite & (wb_dst == rt_r) & (rt_r != REG_W'(REG_ZERO));

    mem_align_chk u_align_chk (
        .addr_lo    (alu_in[1:0]),
        .byte_en    (Byte_in),
        .half_en    (Half_in),
        .access     (access_s),
        .misaligned (misaligned_s)
    );

    // Build the control bundle and store data to capture from EX this cycle.
    always_comb begin
        cap_ctrl_s = '0;
        cap_data_s = rt_data_in;
        if (valid_in) begin
            cap_ctrl_s.reg_write    = RegWrite_in & ~misaligned_s;
            cap_ctrl_s.mem_write    = MemWrite_in & ~misaligned_s;
            cap_ctrl_s.mem_to_reg   = MemtoReg_in & ~misaligned_s;
            cap_ctrl_s.unsigned_ext = UnsignedExt_in;
            cap_ctrl_s.byte_en      = Byte_in;
            cap_ctrl_s.half_en      = Half_in & ~Byte_in;
        end else begin
            cap_ctrl_s = '0;
        end
        if (fwd_s) begin
            cap_data_s = wb_data;
        end else begin
            cap_data_s = rt_data_in;
        end
    end

    // Pipeline fields: reset, bubble, hold-with-snoop, or capture.
    always_ff @(posedge clk) begin
        if (CLR) begin
            ctrl_r     <= '0;
            valid_r    <= 1'b0;
            r1_r       <= '0;
            data_r     <= '0;
            dst_r      <= '0;
            rt_r       <= '0;
            addr_err_r <= 1'b0;
        end else if (flush) begin
            ctrl_r     <= '0;
            valid_r    <= 1'b0;
            r1_r       <= '0;
            data_r     <= '0;
            dst_r      <= '0;
            rt_r       <= '0;
            addr_err_r <= 1'b0;
        end else if (stall) begin
            addr_err_r <= 1'b0;
            if (snoop_s) begin
                data_r <= wb_data;
            end
        end else begin
            ctrl_r     <= cap_ctrl_s;
            valid_r    <= valid_in;
            r1_r       <= alu_in;
            data_r     <= cap_data_s;
            dst_r      <= dst_in;
            rt_r       <= rt_in;
            addr_err_r <= misaligned_s;
        end
    end

    // Sticky fault: first fault wins, unless acknowledged in the same cycle.
    always_ff @(posedge clk) begin
        if (CLR) begin
            fault_r    <= 1'b0;
            bad_addr_r <= '0;
        end else if (capture_s && misaligned_s && (!fault_r || err_ack)) begin
            fault_r    <= 1'b1;
            bad_addr_r <= alu_in;
        end else if (err_ack) begin
            fault_r    <= 1'b0;
            bad_addr_r <= '0;
        end
    end

    assign R1_in           = r1_r;
    assign data_in         = data_r;
    assign MemWrite        = ctrl_r.mem_write;
    assign MemtoReg        = ctrl_r.mem_to_reg;
    assign UnsignedExt_Mem = ctrl_r.unsigned_ext;
    assign Byte            = ctrl_r.byte_en;
    assign Half            = ctrl_r.half_en;
    assign RegWrite        = ctrl_r.reg_write;
    assign dst             = dst_r;
    assign valid           = valid_r;
    assign addr_err        = addr_err_r;
    assign bad_addr        = bad_addr_r;
    assign fault           = fault_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg against a behavioural model, plus directed literal checks.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        CLR, stall, flush, valid_in;
    logic [31:0] alu_in, rt_data_in, wb_data;
    logic [4:0]  rt_in, dst_in, wb_dst;
    logic        RegWrite_in, MemWrite_in, MemtoReg_in, UnsignedExt_in, Byte_in, Half_in;
    logic        wb_RegWrite, err_ack;
    logic [31:0] R1_in, data_in, bad_addr;
    logic        MemWrite, MemtoReg, UnsignedExt_Mem, Byte, Half, RegWrite;
    logic [4:0]  dst;
    logic        valid, addr_err, fault;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // model state: what the MEM-side outputs must be after the latest edge
    logic [31:0] e_r1, e_data, e_bad;
    logic [4:0]  e_dst, e_rt;
    logic        e_valid, e_rw, e_mw, e_m2r, e_ue, e_b, e_h, e_aerr, e_fault;

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .CLR(CLR), .stall(stall), .flush(flush), .valid_in(valid_in),
        .alu_in(alu_in), .rt_data_in(rt_data_in), .rt_in(rt_in), .dst_in(dst_in),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in),
        .UnsignedExt_in(UnsignedExt_in), .Byte_in(Byte_in), .Half_in(Half_in),
        .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst), .wb_data(wb_data), .err_ack(err_ack),
        .R1_in(R1_in), .data_in(data_in), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .UnsignedExt_Mem(UnsignedExt_Mem), .Byte(Byte), .Half(Half), .RegWrite(RegWrite),
        .dst(dst), .valid(valid), .addr_err(addr_err), .bad_addr(bad_addr), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge.
    task automatic model_update();
        int  size;
        bit  acc, mis, cap;
        if (CLR) begin
            {e_valid, e_rw, e_mw, e_m2r, e_ue, e_b, e_h, e_aerr, e_fault} = '0;
            e_r1 = 0; e_data = 0; e_bad = 0; e_dst = 0; e_rt = 0;
            return;
        end
        size = Byte_in ? 1 : (Half_in ? 2 : 4);
        acc  = valid_in && (MemWrite_in || MemtoReg_in);
        mis  = acc && ((alu_in % size) != 0);
        cap  = !flush && !stall;
        if (cap && mis && (!e_fault || err_ack)) begin
            e_fault = 1'b1; e_bad = alu_in;
        end else if (err_ack) begin
            e_fault = 1'b0; e_bad = 0;
        end
        if (flush) begin
            {e_valid, e_rw, e_mw, e_m2r, e_ue, e_b, e_h, e_aerr} = '0;
            e_r1 = 0; e_data = 0; e_dst = 0; e_rt = 0;
        end else if (stall) begin
            e_aerr = 1'b0;
            if (wb_RegWrite && wb_dst == e_rt && e_rt != 0) e_data = wb_data;
        end else begin
            e_valid = valid_in;
            e_r1    = alu_in;
            e_dst   = dst_in;
            e_rt    = rt_in;
            e_data  = (wb_RegWrite && wb_dst == rt_in && rt_in != 0) ? wb_data : rt_data_in;
            e_rw    = valid_in && RegWrite_in && !mis;
            e_mw    = valid_in && MemWrite_in && !mis;
            e_m2r   = valid_in && MemtoReg_in && !mis;
            e_ue    = valid_in && UnsignedExt_in;
            e_b     = valid_in && Byte_in;
            e_h     = valid_in && Half_in && !Byte_in;
            e_aerr  = mis;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        CLR = 0; stall = 0; flush = 0; valid_in = 0; alu_in = 0; rt_data_in = 0;
        rt_in = 0; dst_in = 0; RegWrite_in = 0; MemWrite_in = 0; MemtoReg_in = 0;
        UnsignedExt_in = 0; Byte_in = 0; Half_in = 0; wb_RegWrite = 0; wb_dst = 0;
        wb_data = 0; err_ack = 0;
    endtask

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("R1_in", R1_in, e_r1);
            check("data_in", data_in, e_data);
            check("MemWrite", MemWrite, e_mw);
            check("MemtoReg", MemtoReg, e_m2r);
            check("UnsignedExt_Mem", UnsignedExt_Mem, e_ue);
            check("Byte", Byte, e_b);
            check("Half", Half, e_h);
            check("RegWrite", RegWrite, e_rw);
            check("dst", dst, e_dst);
            check("valid", valid, e_valid);
            check("addr_err", addr_err, e_aerr);
            check("bad_addr", bad_addr, e_bad);
            check("fault", fault, e_fault);
        end
    end

    initial begin
        idle();
        CLR = 1;
        cycle(); cycle();
        chk_en = 1'b1;
        check("rst_valid", valid, 32'd0);
        check("rst_fault", fault, 32'd0);
        check("rst_data", data_in, 32'd0);
        CLR = 0;

        // word store
        valid_in = 1; alu_in = 32'h0000_1004; rt_data_in = 32'hDEAD_BEEF; rt_in = 5'd3; MemWrite_in = 1;
        cycle();
        check("ws_r1", R1_in, 32'h0000_1004);
        check("ws_data", data_in, 32'hDEAD_BEEF);
        check("ws_memwrite", MemWrite, 32'd1);
        check("ws_addr_err", addr_err, 32'd0);

        // forwarding at capture, then rt=0 must not forward
        alu_in = 32'h0000_0100; rt_data_in = 32'h1111_1111; rt_in = 5'd5;
        wb_RegWrite = 1; wb_dst = 5'd5; wb_data = 32'h1234_5678;
        cycle();
        check("fwd_data", data_in, 32'h1234_5678);
        rt_in = 5'd0; wb_dst = 5'd0;
        cycle();
        check("fwd_r0_data", data_in, 32'h1111_1111);

        // stall 3 cycles with WB snoop in the second
        wb_RegWrite = 0; alu_in = 32'h0000_0040; rt_in = 5'd7; rt_data_in = 32'h0BAD_F00D;
        cycle();
        stall = 1; alu_in = 32'hFFFF_FFF0; rt_data_in = 32'h7777_7777; dst_in = 5'd9;
        cycle();
        check("stall1_data", data_in, 32'h0BAD_F00D);
        wb_RegWrite = 1; wb_dst = 5'd7; wb_data = 32'hA5A5_A5A5;
        cycle();
        check("stall2_data", data_in, 32'hA5A5_A5A5);
        check("stall2_r1", R1_in, 32'h0000_0040);
        wb_RegWrite = 0;
        cycle();
        check("stall3_data", data_in, 32'hA5A5_A5A5);
        check("stall3_memwrite", MemWrite, 32'd1);
        stall = 0;

        // misaligned half load, then misaligned word store, then ack
        idle();
        valid_in = 1; MemtoReg_in = 1; RegWrite_in = 1; Half_in = 1; alu_in = 32'h0000_2001;
        cycle();
        check("mis_memtoreg", MemtoReg, 32'd0);
        check("mis_regwrite", RegWrite, 32'd0);
        check("mis_addr_err", addr_err, 32'd1);
        check("mis_bad_addr", bad_addr, 32'h0000_2001);
        check("mis_fault", fault, 32'd1);
        check("mis_valid", valid, 32'd1);
        idle();
        valid_in = 1; MemWrite_in = 1; alu_in = 32'h0000_3002;
        cycle();
        check("mis2_bad_addr", bad_addr, 32'h0000_2001);
        idle();
        cycle();
        check("mis_pulse_end", addr_err, 32'd0);
        err_ack = 1;
        cycle();
        check("ack_fault", fault, 32'd0);
        check("ack_bad_addr", bad_addr, 32'd0);
        err_ack = 0;

        // flush together with stall produces a bubble
        valid_in = 1; MemWrite_in = 1; RegWrite_in = 1; alu_in = 32'h0000_0010; flush = 1; stall = 1;
        cycle();
        check("flush_valid", valid, 32'd0);
        check("flush_memwrite", MemWrite, 32'd0);
        check("flush_regwrite", RegWrite, 32'd0);

        // fault, stall, then CLR mid-stall
        flush = 0; stall = 0; alu_in = 32'h0000_0005; rt_data_in = 32'h5555_0000;
        cycle();
        stall = 1;
        cycle();
        CLR = 1;
        cycle();
        check("clr_r1", R1_in, 32'd0);
        check("clr_data", data_in, 32'd0);
        check("clr_fault", fault, 32'd0);
        check("clr_bad_addr", bad_addr, 32'd0);
        check("clr_valid", valid, 32'd0);

        // Byte and Half together at an odd address: byte access
        idle();
        valid_in = 1; MemtoReg_in = 1; Byte_in = 1; Half_in = 1; alu_in = 32'h0000_0013;
        cycle();
        check("bh_byte", Byte, 32'd1);
        check("bh_half", Half, 32'd0);
        check("bh_addr_err", addr_err, 32'd0);
        check("bh_memtoreg", MemtoReg, 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            CLR            = ($urandom_range(63) == 0);
            flush          = ($urandom_range(7) == 0);
            stall          = ($urandom_range(3) == 0);
            err_ack        = ($urandom_range(15) == 0);
            valid_in       = ($urandom_range(7) != 0);
            alu_in         = $urandom;
            rt_data_in     = $urandom;
            rt_in          = 5'($urandom_range(7));
            dst_in         = 5'($urandom_range(31));
            RegWrite_in    = 1'($urandom_range(1));
            MemWrite_in    = 1'($urandom_range(1));
            MemtoReg_in    = 1'($urandom_range(1));
            UnsignedExt_in = 1'($urandom_range(1));
            Byte_in        = 1'($urandom_range(1));
            Half_in        = 1'($urandom_range(1));
            wb_RegWrite    = 1'($urandom_range(1));
            wb_dst         = 5'($urandom_range(7));
            wb_data        = $urandom;
            cycle();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
